// File: rtl/wishbone_ram_slave.sv
// wishbone_ram_slave
//
// Wishbone classic single-access slave: on-chip 32-bit word RAM with byte-lane
// writes and a fixed number of wait states before termination. Cycles whose
// address falls outside the configured window end with wb_err_o instead of
// wb_ack_o and have no side effect on the RAM.
//
// Parameters
//   ADDR_WIDTH   word-address bits; RAM depth is 2**ADDR_WIDTH words
//   WAIT_STATES  extra cycles inserted before ack/err (0..15)
//   BASE_ADDR    byte base of the window; bits [31:ADDR_WIDTH+2] are compared
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        synchronous active-high reset (RAM contents are kept)
//   wb_adr_i   byte address, bits [1:0] ignored
//   wb_dat_i   write data
//   wb_dat_o   read data, zero whenever wb_ack_o is low
//   wb_we_i    1 = write, 0 = read
//   wb_sel_i   byte-lane enables for writes; reads always return the full word
//   wb_stb_i   strobe
//   wb_cyc_i   bus cycle valid
//   wb_ack_o   normal termination, one-cycle pulse
//   wb_err_o   error termination (address outside window), one-cycle pulse

module wishbone_ram_slave #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    localparam int unsigned Depth    = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  WaitInit = WAIT_STATES[3:0];

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      wait_cnt_q, wait_cnt_d;
    logic            ack_q;
    logic            err_q;
    logic [31:0]     dat_q;

    logic [31:0]     mem [Depth];

    logic                  req;
    logic                  hit;
    logic                  term;     // this edge enters StResp
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  unused_adr_lsb;

    assign req      = wb_cyc_i & wb_stb_i;
    assign hit      = (wb_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign word_idx = wb_adr_i[ADDR_WIDTH+1:2];

    // Byte offset within a word carries no meaning for a word RAM.
    assign unused_adr_lsb = ^wb_adr_i[1:0];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        term       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    wait_cnt_d = WaitInit;
                    if (WAIT_STATES == 0) begin
                        state_d = StResp;
                        term    = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end

            StWait: begin
                if (!req) begin
                    // Initiator withdrew the request: abort without side effects.
                    state_d    = StIdle;
                    wait_cnt_d = 4'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                    if (wait_cnt_q == 4'd1) begin
                        state_d = StResp;
                        term    = 1'b1;
                    end
                end
            end

            // Response cycle ignores the still-asserted request so the
            // initiator has one cycle to drop stb/cyc after seeing ack.
            StResp: begin
                state_d = StIdle;
            end

            default: begin
                state_d    = StIdle;
                wait_cnt_d = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wait_cnt_q <= 4'd0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            ack_q      <= term & hit;
            err_q      <= term & ~hit;
            // Read data is only driven for the single ack cycle of a read hit.
            if (term && hit && !wb_we_i) begin
                dat_q <= mem[word_idx];
            end else begin
                dat_q <= 32'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // RAM write port; no reset so contents survive rst.
    // ------------------------------------------------------------------
    assign mem_we = ~rst & term & hit & wb_we_i;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wb_sel_i[b]) begin
                    mem[word_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
                end
            end
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_wishbone_ram_slave.sv
// Bench for wishbone_ram_slave. Three instances cover WAIT_STATES = 1, 3 and 0
// (the last with a non-zero window base). A transaction-level model counts
// consecutive request edges per instance and predicts ack/err/data for every
// cycle; directed transfers pin latency and read data with literal values.

module tb_wishbone_ram_slave;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic [31:0] adr_s  [N];
    logic [31:0] wdat_s [N];
    logic        we_s   [N];
    logic [3:0]  sel_s  [N];
    logic        stb_s  [N];
    logic        cyc_s  [N];
    logic [31:0] rdat_o [N];
    logic        ack_o  [N];
    logic        err_o  [N];

    int n_checks = 0;
    int n_fail   = 0;

    wishbone_ram_slave #(
        .ADDR_WIDTH (10),
        .WAIT_STATES(1),
        .BASE_ADDR  (32'h0000_0000)
    ) u_ws1 (
        .clk     (clk),
        .rst     (rst),
        .wb_adr_i(adr_s[0]),
        .wb_dat_i(wdat_s[0]),
        .wb_dat_o(rdat_o[0]),
        .wb_we_i (we_s[0]),
        .wb_sel_i(sel_s[0]),
        .wb_stb_i(stb_s[0]),
        .wb_cyc_i(cyc_s[0]),
        .wb_ack_o(ack_o[0]),
        .wb_err_o(err_o[0])
    );

    wishbone_ram_slave #(
        .ADDR_WIDTH (10),
        .WAIT_STATES(3),
        .BASE_ADDR  (32'h0000_0000)
    ) u_ws3 (
        .clk     (clk),
        .rst     (rst),
        .wb_adr_i(adr_s[1]),
        .wb_dat_i(wdat_s[1]),
        .wb_dat_o(rdat_o[1]),
        .wb_we_i (we_s[1]),
        .wb_sel_i(sel_s[1]),
        .wb_stb_i(stb_s[1]),
        .wb_cyc_i(cyc_s[1]),
        .wb_ack_o(ack_o[1]),
        .wb_err_o(err_o[1])
    );

    wishbone_ram_slave #(
        .ADDR_WIDTH (10),
        .WAIT_STATES(0),
        .BASE_ADDR  (32'h0001_0000)
    ) u_ws0 (
        .clk     (clk),
        .rst     (rst),
        .wb_adr_i(adr_s[2]),
        .wb_dat_i(wdat_s[2]),
        .wb_dat_o(rdat_o[2]),
        .wb_we_i (we_s[2]),
        .wb_sel_i(sel_s[2]),
        .wb_stb_i(stb_s[2]),
        .wb_cyc_i(cyc_s[2]),
        .wb_ack_o(ack_o[2]),
        .wb_err_o(err_o[2])
    );

    function automatic int ws_of(input int d);
        case (d)
            0:       return 1;
            1:       return 3;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] base_of(input int d);
        return (d == 2) ? 32'h0001_0000 : 32'h0000_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: an access terminates on the (WS+1)-th consecutive edge that
    // sees a request; the cycle after a termination ignores requests.
    // ------------------------------------------------------------------
    int          age  [N];
    bit          cool [N];
    bit          mdl_valid = 1'b0;
    logic        exp_ack [N];
    logic        exp_err [N];
    logic [31:0] exp_dat [N];
    logic [31:0] mdl_mem [N][1024];

    always @(posedge clk) begin
        for (int d = 0; d < N; d++) begin
            exp_ack[d] = 1'b0;
            exp_err[d] = 1'b0;
            exp_dat[d] = 32'd0;
            if (rst) begin
                age[d]  = 0;
                cool[d] = 1'b0;
            end else if (cool[d]) begin
                cool[d] = 1'b0;
            end else if (cyc_s[d] && stb_s[d]) begin
                age[d]++;
                if (age[d] == ws_of(d) + 1) begin
                    age[d]  = 0;
                    cool[d] = 1'b1;
                    if ((adr_s[d] >> 12) == (base_of(d) >> 12)) begin
                        exp_ack[d] = 1'b1;
                        if (we_s[d]) begin
                            for (int b = 0; b < 4; b++) begin
                                if (sel_s[d][b]) begin
                                    mdl_mem[d][adr_s[d][11:2]][8*b +: 8] = wdat_s[d][8*b +: 8];
                                end
                            end
                        end else begin
                            exp_dat[d] = mdl_mem[d][adr_s[d][11:2]];
                        end
                    end else begin
                        exp_err[d] = 1'b1;
                    end
                end
            end else begin
                age[d] = 0;
            end
        end
        if (rst) mdl_valid = 1'b1;
    end

    // Compare every cycle once the model has seen a reset edge.
    always @(negedge clk) begin
        if (mdl_valid) begin
            for (int d = 0; d < N; d++) begin
                check($sformatf("ack[%0d]", d), {31'd0, ack_o[d]}, {31'd0, exp_ack[d]});
                check($sformatf("err[%0d]", d), {31'd0, err_o[d]}, {31'd0, exp_err[d]});
                check($sformatf("dat[%0d]", d), rdat_o[d], exp_dat[d]);
            end
        end
    end

    // ------------------------------------------------------------------
    // One complete access; lat counts cycles from the first request edge
    // until the terminating pulse is visible.
    // ------------------------------------------------------------------
    task automatic xfer(input int d, input bit we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        output logic [31:0] rdat, output int lat,
                        output bit got_ack, output bit got_err);
        @(posedge clk);
        #1;
        cyc_s[d]  = 1'b1;
        stb_s[d]  = 1'b1;
        we_s[d]   = we;
        adr_s[d]  = adr;
        wdat_s[d] = dat;
        sel_s[d]  = sel;
        lat       = 0;
        got_ack   = 1'b0;
        got_err   = 1'b0;
        rdat      = 32'd0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (ack_o[d] || err_o[d]) begin
                got_ack = ack_o[d];
                got_err = err_o[d];
                rdat    = rdat_o[d];
                break;
            end
        end
        @(posedge clk);
        #1;
        cyc_s[d] = 1'b0;
        stb_s[d] = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        int          hits;
        bit          a;
        bit          e;

        rst = 1'b1;
        for (int d = 0; d < N; d++) begin
            adr_s[d]  = 32'd0;
            wdat_s[d] = 32'd0;
            we_s[d]   = 1'b0;
            sel_s[d]  = 4'd0;
            stb_s[d]  = 1'b0;
            cyc_s[d]  = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ack", {31'd0, ack_o[0]}, 32'd0);
        check("reset err", {31'd0, err_o[0]}, 32'd0);
        check("reset dat", rdat_o[0], 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full write then read, one wait state.
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat, a, e);
        check("t1 wr ack", {31'd0, a}, 32'd1);
        check("t1 wr lat", lat, 32'd2);
        @(negedge clk);
        check("t1 ack width", {31'd0, ack_o[0]}, 32'd0);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, lat, a, e);
        check("t1 rd data", rd, 32'hDEADBEEF);
        check("t1 rd lat", lat, 32'd2);
        @(negedge clk);
        check("t1 dat after ack", rdat_o[0], 32'd0);

        // Byte-lane write and an all-lanes-off write.
        xfer(0, 1'b1, 32'h10, 32'h0000AB00, 4'b0010, rd, lat, a, e);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, lat, a, e);
        check("t2 byte write", rd, 32'hDEADABEF);
        xfer(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, lat, a, e);
        check("t2 sel0 ack", {31'd0, a}, 32'd1);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, lat, a, e);
        check("t2 sel0 unchanged", rd, 32'hDEADABEF);

        // Window edges: word 0, top word, first address past the window.
        xfer(0, 1'b1, 32'h0, 32'h11112222, 4'hF, rd, lat, a, e);
        xfer(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, rd, lat, a, e);
        check("t3 miss wr err", {31'd0, e}, 32'd1);
        check("t3 miss wr ack", {31'd0, a}, 32'd0);
        xfer(0, 1'b0, 32'h1000, 32'h0, 4'hF, rd, lat, a, e);
        check("t3 miss rd err", {31'd0, e}, 32'd1);
        check("t3 miss rd dat", rd, 32'd0);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, rd, lat, a, e);
        check("t3 word0 no alias", rd, 32'h11112222);
        xfer(0, 1'b1, 32'hFFC, 32'hA5A5C3C3, 4'hF, rd, lat, a, e);
        xfer(0, 1'b0, 32'hFFC, 32'h0, 4'hF, rd, lat, a, e);
        check("t3 top word", rd, 32'hA5A5C3C3);

        // stb without cyc is not a request.
        @(posedge clk);
        #1;
        stb_s[0] = 1'b1;
        we_s[0]  = 1'b1;
        adr_s[0] = 32'h10;
        hits     = 0;
        repeat (5) begin
            @(negedge clk);
            if (ack_o[0] || err_o[0]) hits++;
        end
        stb_s[0] = 1'b0;
        check("stb no cyc", hits, 32'd0);

        // Three wait states, then an aborted write.
        xfer(1, 1'b1, 32'h20, 32'h01020304, 4'hF, rd, lat, a, e);
        check("t4 wr lat", lat, 32'd4);
        @(posedge clk);
        #1;
        cyc_s[1]  = 1'b1;
        stb_s[1]  = 1'b1;
        we_s[1]   = 1'b1;
        adr_s[1]  = 32'h20;
        wdat_s[1] = 32'hFFFFFFFF;
        sel_s[1]  = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        cyc_s[1] = 1'b0;
        stb_s[1] = 1'b0;
        hits     = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack_o[1] || err_o[1]) hits++;
        end
        check("t4 abort no term", hits, 32'd0);
        xfer(1, 1'b0, 32'h20, 32'h0, 4'hF, rd, lat, a, e);
        check("t4 abort ram", rd, 32'h01020304);

        // Reset in the middle of a write's wait phase.
        xfer(1, 1'b1, 32'h24, 32'hCAFEF00D, 4'hF, rd, lat, a, e);
        @(posedge clk);
        #1;
        cyc_s[1]  = 1'b1;
        stb_s[1]  = 1'b1;
        we_s[1]   = 1'b1;
        adr_s[1]  = 32'h24;
        wdat_s[1] = 32'h00000000;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        cyc_s[1] = 1'b0;
        stb_s[1] = 1'b0;
        @(negedge clk);
        check("t5 rst ack", {31'd0, ack_o[1]}, 32'd0);
        check("t5 rst err", {31'd0, err_o[1]}, 32'd0);
        check("t5 rst dat", rdat_o[1], 32'd0);
        xfer(1, 1'b0, 32'h24, 32'h0, 4'hF, rd, lat, a, e);
        check("t5 no write", rd, 32'hCAFEF00D);
        check("t5 post-rst lat", lat, 32'd4);
        xfer(1, 1'b0, 32'h20, 32'h0, 4'hF, rd, lat, a, e);
        check("t5 intact ws3", rd, 32'h01020304);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, lat, a, e);
        check("t5 intact ws1", rd, 32'hDEADABEF);

        // Zero wait states, window based at 0x0001_0000.
        xfer(2, 1'b1, 32'h0001_0040, 32'h12345678, 4'hF, rd, lat, a, e);
        check("t6 sw ack", {31'd0, a}, 32'd1);
        check("t6 sw lat", lat, 32'd1);
        xfer(2, 1'b0, 32'h0001_0040, 32'h0, 4'hF, rd, lat, a, e);
        check("t6 lw lat", lat, 32'd1);
        check("t6 lw data", rd, 32'h12345678);
        xfer(2, 1'b0, 32'h0000_0040, 32'h0, 4'hF, rd, lat, a, e);
        check("t6 below base err", {31'd0, e}, 32'd1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
